// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SDRAM port arbiter.
// The arbiter, its request slots and the bench all import this package.
package sram_arb_pkg;

    localparam int AW_DEF = 25;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IO,
        GNT_CPU,
        GNT_TAPE
    } grant_t;

endpackage

// File: rtl/sram_arb_slot.sv
// One-entry request buffer: holds a single pending command until the arbiter clears it.
// A load that arrives while full, and is not paired with a clear, is dropped and flagged.
module sram_arb_slot #(
    parameter int AW = 25,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          load_we,
    output logic          pending,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          we,
    output logic          drop
);

    // A clear in the same cycle frees the entry, so the new load is kept.
    logic accept;
    assign accept = load && (!pending || clear);
    assign drop   = load && pending && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            addr    <= '0;
            data    <= '0;
            we      <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
            addr    <= load_addr;
            data    <= load_data;
            we      <= load_we;
        end else if (clear) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the byte-wide SDRAM port between data_io downloads, the CPU and tape playback.
// Priority io > cpu > tape; tape is only granted inside Z80 refresh windows.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          io_wr,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_din,
    output logic          io_busy,
    output logic          io_overrun,
    input  logic          cpu_rd,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_wait,
    input  logic          rfsh,
    input  logic          tape_req,
    input  logic [AW-1:0] tape_addr,
    output logic [DW-1:0] tape_dout,
    output logic          tape_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_rd,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_dout,
    input  logic          mem_dvalid
);

    // Handshake: mem_we/mem_rd act as valid and stay high, with mem_addr/mem_din
    // frozen, until a cycle where mem_ready is sampled high; that cycle transfers.
    state_t  state, next_state;
    grant_t  grant, next_grant;

    logic          io_pend, cpu_pend, tape_pend;
    logic [AW-1:0] io_a, cpu_a, tape_a;
    logic [DW-1:0] io_d, cpu_d, tape_d;
    logic          io_w, cpu_w, tape_w;
    logic          io_drop, cpu_drop, tape_drop;
    logic          clr_io, clr_cpu, clr_tape;
    logic          cpu_prev, cpu_rise, done;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          sel_we;
    logic          unused_drops;

    assign cpu_rise     = (cpu_rd || cpu_we) && !cpu_prev;
    assign unused_drops = cpu_drop | tape_drop;

    sram_arb_slot #(.AW(AW), .DW(DW)) u_io_slot (
        .clk(clk), .reset(reset), .load(io_wr), .clear(clr_io),
        .load_addr(io_addr), .load_data(io_din), .load_we(1'b1),
        .pending(io_pend), .addr(io_a), .data(io_d), .we(io_w), .drop(io_drop)
    );

    sram_arb_slot #(.AW(AW), .DW(DW)) u_cpu_slot (
        .clk(clk), .reset(reset), .load(cpu_rise), .clear(clr_cpu),
        .load_addr(cpu_addr), .load_data(cpu_din), .load_we(cpu_we),
        .pending(cpu_pend), .addr(cpu_a), .data(cpu_d), .we(cpu_w), .drop(cpu_drop)
    );

    sram_arb_slot #(.AW(AW), .DW(DW)) u_tape_slot (
        .clk(clk), .reset(reset), .load(tape_req), .clear(clr_tape),
        .load_addr(tape_addr), .load_data('0), .load_we(1'b0),
        .pending(tape_pend), .addr(tape_a), .data(tape_d), .we(tape_w), .drop(tape_drop)
    );

    always_comb begin
        next_state = state;
        next_grant = grant;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (io_pend) begin
                    next_grant = GNT_IO;
                    next_state = ST_ISSUE;
                end else if (cpu_pend) begin
                    next_grant = GNT_CPU;
                    next_state = ST_ISSUE;
                end else if (tape_pend && rfsh) begin
                    next_grant = GNT_TAPE;
                    next_state = ST_ISSUE;
                end else begin
                    next_grant = GNT_NONE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    if (mem_we) begin
                        done       = 1'b1;
                        next_grant = GNT_NONE;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (mem_dvalid) begin
                    done       = 1'b1;
                    next_grant = GNT_NONE;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_grant = GNT_NONE;
                next_state = ST_IDLE;
            end
        endcase
    end

    assign clr_io   = done && (grant == GNT_IO);
    assign clr_cpu  = done && (grant == GNT_CPU);
    assign clr_tape = done && (grant == GNT_TAPE);

    always_comb begin
        sel_addr = io_a;
        sel_data = io_d;
        sel_we   = io_w;
        case (next_grant)
            GNT_CPU: begin
                sel_addr = cpu_a;
                sel_data = cpu_d;
                sel_we   = cpu_w;
            end
            GNT_TAPE: begin
                sel_addr = tape_a;
                sel_data = tape_d;
                sel_we   = tape_w;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= GNT_NONE;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_rd     <= 1'b0;
            cpu_dout   <= '0;
            tape_dout  <= '0;
            tape_valid <= 1'b0;
            io_overrun <= 1'b0;
            cpu_prev   <= 1'b0;
        end else begin
            state      <= next_state;
            grant      <= next_grant;
            cpu_prev   <= cpu_rd || cpu_we;
            tape_valid <= 1'b0;
            if (io_drop) io_overrun <= 1'b1;
            if (state == ST_IDLE && next_state == ST_ISSUE) begin
                mem_addr <= sel_addr;
                mem_din  <= sel_data;
                mem_we   <= sel_we;
                mem_rd   <= !sel_we;
            end else if (state == ST_ISSUE && mem_ready) begin
                mem_we <= 1'b0;
                mem_rd <= 1'b0;
            end
            // Read data is routed by the grant latched at issue time.
            if (state == ST_WAIT_RD && mem_dvalid) begin
                if (grant == GNT_CPU) cpu_dout <= mem_dout;
                if (grant == GNT_TAPE) begin
                    tape_dout  <= mem_dout;
                    tape_valid <= 1'b1;
                end
            end
        end
    end

    assign io_busy  = io_pend;
    assign cpu_wait = cpu_pend || cpu_rise;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_sram_arbiter;

    localparam int AW = 25;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_wr;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_din;
    logic          io_busy, io_overrun;
    logic          cpu_rd, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          cpu_wait;
    logic          rfsh, tape_req;
    logic [AW-1:0] tape_addr;
    logic [DW-1:0] tape_dout;
    logic          tape_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we, mem_rd, mem_ready;
    logic [DW-1:0] mem_dout;
    logic          mem_dvalid;

    int n_vec = 0;
    int n_err = 0;

    sram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .io_wr(io_wr), .io_addr(io_addr), .io_din(io_din),
        .io_busy(io_busy), .io_overrun(io_overrun),
        .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .rfsh(rfsh), .tape_req(tape_req), .tape_addr(tape_addr),
        .tape_dout(tape_dout), .tape_valid(tape_valid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_ready(mem_ready), .mem_dout(mem_dout), .mem_dvalid(mem_dvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        io_wr = 0; io_addr = '0; io_din = '0;
        cpu_rd = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
        rfsh = 0; tape_req = 0; tape_addr = '0;
        mem_ready = 0; mem_dout = '0; mem_dvalid = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset;
        do_reset();
        n_vec++;
        if ({io_busy, io_overrun, cpu_wait, tape_valid, mem_we, mem_rd} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {io_busy, io_overrun, cpu_wait, tape_valid, mem_we, mem_rd});
        end
        n_vec++;
        if (cpu_dout !== 8'h00 || tape_dout !== 8'h00 || mem_din !== 8'h00 || mem_addr !== 25'h0) begin
            n_err++;
            $display("FAIL reset_data: cpu_dout=%h tape_dout=%h mem_din=%h mem_addr=%h want all 0",
                     cpu_dout, tape_dout, mem_din, mem_addr);
        end
    endtask

    task automatic test_io_write;
        do_reset();
        mem_ready = 1;
        io_wr = 1; io_addr = 25'h0C000; io_din = 8'hA5;
        tick();
        io_wr = 0;
        n_vec++;
        if (io_busy !== 1'b1 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL io_write_t1: io_busy=%b mem_we=%b want 1 0", io_busy, mem_we);
        end
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 25'h0C000 || mem_din !== 8'hA5) begin
            n_err++;
            $display("FAIL io_write_t2: we=%b rd=%b addr=%h din=%h want 1 0 0c000 a5",
                     mem_we, mem_rd, mem_addr, mem_din);
        end
        tick();
        n_vec++;
        if (mem_we !== 1'b0 || io_busy !== 1'b0) begin
            n_err++;
            $display("FAIL io_write_t3: mem_we=%b io_busy=%b want 0 0", mem_we, io_busy);
        end
    endtask

    task automatic test_overrun;
        do_reset();
        io_wr = 1; io_addr = 25'h1; io_din = 8'h11;
        tick();
        io_addr = 25'h2; io_din = 8'h22;
        tick();
        io_wr = 0;
        n_vec++;
        if (io_overrun !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 25'h1) begin
            n_err++;
            $display("FAIL overrun_flag: overrun=%b we=%b addr=%h want 1 1 1", io_overrun, mem_we, mem_addr);
        end
        tick();
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 25'h1 || mem_din !== 8'h11) begin
            n_err++;
            $display("FAIL overrun_hold: we=%b addr=%h din=%h want 1 1 11", mem_we, mem_addr, mem_din);
        end
        mem_ready = 1;
        tick();
        mem_ready = 0;
        n_vec++;
        if (mem_we !== 1'b0 || io_busy !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_accept: we=%b io_busy=%b want 0 0", mem_we, io_busy);
        end
        repeat (4) tick();
        n_vec++;
        if (mem_we !== 1'b0 || mem_rd !== 1'b0 || io_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_sticky: we=%b rd=%b overrun=%b want 0 0 1", mem_we, mem_rd, io_overrun);
        end
        do_reset();
        n_vec++;
        if (io_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_reset: overrun=%b want 0", io_overrun);
        end
    endtask

    task automatic test_cpu_read;
        logic wait_ok;
        do_reset();
        mem_ready = 1;
        cpu_rd = 1; cpu_addr = 25'h14000;
        #1;
        wait_ok = cpu_wait;
        tick();
        wait_ok = wait_ok & cpu_wait;
        tick();
        wait_ok = wait_ok & cpu_wait;
        n_vec++;
        if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 25'h14000) begin
            n_err++;
            $display("FAIL cpu_read_issue: rd=%b we=%b addr=%h want 1 0 14000", mem_rd, mem_we, mem_addr);
        end
        tick();
        n_vec++;
        if (mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_strobe_drop: rd=%b want 0", mem_rd);
        end
        repeat (3) begin
            wait_ok = wait_ok & cpu_wait;
            tick();
        end
        wait_ok = wait_ok & cpu_wait;
        n_vec++;
        if (wait_ok !== 1'b1 || cpu_dout !== 8'h00) begin
            n_err++;
            $display("FAIL cpu_read_wait: wait_held=%b dout=%h want 1 00", wait_ok, cpu_dout);
        end
        mem_dvalid = 1; mem_dout = 8'h3C;
        tick();
        mem_dvalid = 0;
        n_vec++;
        if (cpu_dout !== 8'h3C || cpu_wait !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_data: dout=%h wait=%b want 3c 0", cpu_dout, cpu_wait);
        end
        repeat (3) tick();
        n_vec++;
        if (cpu_wait !== 1'b0 || mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_once: wait=%b rd=%b want 0 0", cpu_wait, mem_rd);
        end
        cpu_rd = 0;
    endtask

    task automatic test_tape;
        logic quiet;
        do_reset();
        mem_ready = 1;
        tape_req = 1; tape_addr = 25'h1000;
        tick();
        tape_req = 0;
        quiet = 1'b1;
        repeat (10) begin
            if (mem_rd !== 1'b0 || mem_we !== 1'b0) quiet = 1'b0;
            tick();
        end
        n_vec++;
        if (quiet !== 1'b1) begin
            n_err++;
            $display("FAIL tape_no_rfsh: command seen outside refresh window, quiet=%b want 1", quiet);
        end
        rfsh = 1;
        tick();
        n_vec++;
        if (mem_rd !== 1'b1 || mem_addr !== 25'h1000) begin
            n_err++;
            $display("FAIL tape_issue: rd=%b addr=%h want 1 1000", mem_rd, mem_addr);
        end
        rfsh = 0;
        tick();
        mem_dvalid = 1; mem_dout = 8'h5A;
        tick();
        mem_dvalid = 0;
        n_vec++;
        if (tape_valid !== 1'b1 || tape_dout !== 8'h5A) begin
            n_err++;
            $display("FAIL tape_data: valid=%b dout=%h want 1 5a", tape_valid, tape_dout);
        end
        tick();
        n_vec++;
        if (tape_valid !== 1'b0 || tape_dout !== 8'h5A) begin
            n_err++;
            $display("FAIL tape_pulse: valid=%b dout=%h want 0 5a", tape_valid, tape_dout);
        end
    endtask

    task automatic test_priority;
        do_reset();
        mem_ready = 1; rfsh = 1;
        io_wr = 1; io_addr = 25'h100; io_din = 8'h01;
        cpu_we = 1; cpu_addr = 25'h200; cpu_din = 8'h02;
        tape_req = 1; tape_addr = 25'h300;
        tick();
        io_wr = 0; tape_req = 0;
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 25'h100 || mem_din !== 8'h01) begin
            n_err++;
            $display("FAIL prio_io: we=%b addr=%h din=%h want 1 100 01", mem_we, mem_addr, mem_din);
        end
        tick();
        n_vec++;
        if (mem_we !== 1'b0 || mem_rd !== 1'b0) begin
            n_err++;
            $display("FAIL prio_idle_gap: we=%b rd=%b want 0 0", mem_we, mem_rd);
        end
        tick();
        n_vec++;
        if (mem_we !== 1'b1 || mem_addr !== 25'h200 || mem_din !== 8'h02 || cpu_wait !== 1'b1) begin
            n_err++;
            $display("FAIL prio_cpu: we=%b addr=%h din=%h wait=%b want 1 200 02 1",
                     mem_we, mem_addr, mem_din, cpu_wait);
        end
        tick();
        n_vec++;
        if (cpu_wait !== 1'b0) begin
            n_err++;
            $display("FAIL prio_cpu_done: wait=%b want 0", cpu_wait);
        end
        cpu_we = 0;
        tick();
        n_vec++;
        if (mem_rd !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 25'h300) begin
            n_err++;
            $display("FAIL prio_tape: rd=%b we=%b addr=%h want 1 0 300", mem_rd, mem_we, mem_addr);
        end
        tick();
        mem_dvalid = 1; mem_dout = 8'h77;
        tick();
        mem_dvalid = 0;
        n_vec++;
        if (tape_valid !== 1'b1 || tape_dout !== 8'h77) begin
            n_err++;
            $display("FAIL prio_tape_data: valid=%b dout=%h want 1 77", tape_valid, tape_dout);
        end
        rfsh = 0;
    endtask

    task automatic test_reset_wait_rd;
        do_reset();
        mem_ready = 1;
        cpu_rd = 1; cpu_addr = 25'h14000;
        tick();
        tick();
        n_vec++;
        if (mem_rd !== 1'b1) begin
            n_err++;
            $display("FAIL rst_rd_issue: rd=%b want 1", mem_rd);
        end
        tick();
        reset = 1; cpu_rd = 0;
        tick();
        reset = 0;
        mem_dvalid = 1; mem_dout = 8'h99;
        tick();
        mem_dvalid = 0;
        n_vec++;
        if (cpu_dout !== 8'h00 || cpu_wait !== 1'b0 || tape_valid !== 1'b0 ||
            mem_rd !== 1'b0 || mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rd_discard: dout=%h wait=%b tvalid=%b rd=%b we=%b want 00 0 0 0 0",
                     cpu_dout, cpu_wait, tape_valid, mem_rd, mem_we);
        end
        repeat (3) tick();
        n_vec++;
        if (mem_rd !== 1'b0 || mem_we !== 1'b0 || cpu_dout !== 8'h00) begin
            n_err++;
            $display("FAIL rst_rd_quiet: rd=%b we=%b dout=%h want 0 0 00", mem_rd, mem_we, cpu_dout);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_io_write();
        test_overrun();
        test_cpu_read();
        test_tape();
        test_priority();
        test_reset_wait_rd();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
